// File: rtl/mac_array_if.sv
// Bus bundle for mac_array: host dimension/run request plus the weight, input
// and output SRAM ports. Signal names match the original flat port list.
interface mac_array_if;
  logic [11:0] MNT;
  logic        START;
  logic        EN_W;
  logic [2:0]  ADDR_W;
  logic [63:0] RDATA_W;
  logic        EN_I;
  logic [2:0]  ADDR_I;
  logic [63:0] RDATA_I;
  logic        EN_O;
  logic        RW_O;
  logic [3:0]  ADDR_O;
  logic [63:0] WDATA_O;
  logic [63:0] RDATA_O;

  modport master (
    input  MNT, START, RDATA_W, RDATA_I, RDATA_O,
    output EN_W, ADDR_W, EN_I, ADDR_I, EN_O, RW_O, ADDR_O, WDATA_O
  );

  modport slave (
    output MNT, START, RDATA_W, RDATA_I, RDATA_O,
    input  EN_W, ADDR_W, EN_I, ADDR_I, EN_O, RW_O, ADDR_O, WDATA_O
  );
endinterface

// File: rtl/mac_array.sv
// 8x8 int8 matrix-multiply engine: loads input rows and transposed weight rows
// from SRAM, then streams 16-bit wrapped dot products to the output SRAM.
module mac_array #(
  parameter int unsigned DW  = 8,
  parameter int unsigned OW  = 16,
  parameter int unsigned DIM = 8
) (
  input logic         CLK,
  input logic         RSTN,
  mac_array_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_GAP, S_WRITE, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         m_q, m_d, n_q, n_d, t_q, t_d;
  logic               en_r_q, en_r_d;
  logic [2:0]         addr_r_q, addr_r_d;
  logic               en_o_q, en_o_d;
  logic [3:0]         addr_o_q, addr_o_d;
  logic [4*OW-1:0]    wdata_q, wdata_d;
  logic               cap_q, cap_d;
  logic [2:0]         cap_idx_q, cap_idx_d;
  logic [DIM*DW-1:0]  w_bank_q [DIM];
  logic [DIM*DW-1:0]  w_bank_d [DIM];
  logic [DIM*DW-1:0]  i_bank_q [DIM];
  logic [DIM*DW-1:0]  i_bank_d [DIM];

  logic [3:0]         word_k;
  logic [2:0]         calc_row, calc_col;
  logic signed [OW-1:0] calc_acc, calc_a, calc_b;
  logic [4*OW-1:0]    word_calc;
  logic               unused_rdata_o;

  assign unused_rdata_o = ^bus.RDATA_O;

  function automatic logic [3:0] clamp_dim(input logic [3:0] f);
    return (f == 4'd0 || f > 4'd8) ? 4'd8 : f;
  endfunction

  // Word for the next write cycle; every row it needs is already banked,
  // since row 7 of W is first used by word 1 and row 7 of IN by word 14.
  always_comb begin
    word_k    = (state_q == S_WRITE) ? cnt_q + 4'd1 : '0;
    calc_row  = word_k[3:1];
    calc_col  = '0;
    calc_acc  = '0;
    calc_a    = '0;
    calc_b    = '0;
    word_calc = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      calc_col = {word_k[0], 2'(j)};
      calc_acc = '0;
      for (int unsigned n = 0; n < DIM; n++) begin
        calc_a = OW'($signed(i_bank_q[calc_row][DW*(DIM-1-n) +: DW]));
        calc_b = OW'($signed(w_bank_q[calc_col][DW*(DIM-1-n) +: DW]));
        if (4'(n) < n_q) calc_acc = calc_acc + calc_a * calc_b;
      end
      if ({1'b0, calc_row} >= t_q || {1'b0, calc_col} >= m_q) calc_acc = '0;
      word_calc[OW*(3-j) +: OW] = calc_acc;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    n_d       = n_q;
    t_d       = t_q;
    en_r_d    = 1'b0;
    addr_r_d  = '0;
    en_o_d    = 1'b0;
    addr_o_d  = '0;
    wdata_d   = '0;
    cap_d     = en_r_q;
    cap_idx_d = addr_r_q;
    w_bank_d  = w_bank_q;
    i_bank_d  = i_bank_q;
    // Read data arrives one cycle after its address was issued.
    if (cap_q) begin
      w_bank_d[cap_idx_q] = bus.RDATA_W;
      i_bank_d[cap_idx_q] = bus.RDATA_I;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.START == 1'b1) begin
          state_d = S_READ;
          cnt_d   = '0;
          m_d     = clamp_dim(bus.MNT[11:8]);
          n_d     = clamp_dim(bus.MNT[7:4]);
          t_d     = clamp_dim(bus.MNT[3:0]);
          en_r_d  = 1'b1;
        end
      end
      S_READ: begin
        if (cnt_q == 4'd7) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + 4'd1;
          en_r_d   = 1'b1;
          addr_r_d = cnt_q[2:0] + 3'd1;
        end
      end
      S_GAP: begin
        state_d = S_WRITE;
        cnt_d   = '0;
        en_o_d  = 1'b1;
        wdata_d = word_calc;
      end
      S_WRITE: begin
        if (cnt_q == 4'd15) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + 4'd1;
          en_o_d   = 1'b1;
          addr_o_d = cnt_q + 4'd1;
          wdata_d  = word_calc;
        end
      end
      S_DONE: begin
        if (bus.START == 1'b0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      m_q       <= 4'd8;
      n_q       <= 4'd8;
      t_q       <= 4'd8;
      en_r_q    <= 1'b0;
      addr_r_q  <= '0;
      en_o_q    <= 1'b0;
      addr_o_q  <= '0;
      wdata_q   <= '0;
      cap_q     <= 1'b0;
      cap_idx_q <= '0;
      w_bank_q  <= '{default: '0};
      i_bank_q  <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      n_q       <= n_d;
      t_q       <= t_d;
      en_r_q    <= en_r_d;
      addr_r_q  <= addr_r_d;
      en_o_q    <= en_o_d;
      addr_o_q  <= addr_o_d;
      wdata_q   <= wdata_d;
      cap_q     <= cap_d;
      cap_idx_q <= cap_idx_d;
      w_bank_q  <= w_bank_d;
      i_bank_q  <= i_bank_d;
    end
  end

  assign bus.EN_W    = en_r_q;
  assign bus.EN_I    = en_r_q;
  assign bus.ADDR_W  = addr_r_q;
  assign bus.ADDR_I  = addr_r_q;
  assign bus.EN_O    = en_o_q;
  assign bus.RW_O    = en_o_q;
  assign bus.ADDR_O  = addr_o_q;
  assign bus.WDATA_O = wdata_q;

endmodule

// File: tb/tb_mac_array.sv
// Testbench for mac_array: SRAM models, matrix-product reference model and a
// write-side scoreboard monitor.
module tb_mac_array;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  mac_array_if bus();

  mac_array #(.DW(8), .OW(16), .DIM(8)) dut (
    .CLK  (CLK),
    .RSTN (rst),
    .bus  (bus.master)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
  } exp_t;

  logic [7:0] mem_i [8][8];
  logic [7:0] mem_w [8][8];
  exp_t       exp_q [$];
  exp_t       mon_e;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic logic [63:0] row_i(input logic [2:0] a);
    logic [63:0] v;
    for (int n = 0; n < 8; n++) v[63-8*n -: 8] = mem_i[a][n];
    return v;
  endfunction

  function automatic logic [63:0] row_w(input logic [2:0] a);
    logic [63:0] v;
    for (int n = 0; n < 8; n++) v[63-8*n -: 8] = mem_w[a][n];
    return v;
  endfunction

  always @(posedge CLK) begin
    if (bus.EN_I) bus.RDATA_I <= row_i(bus.ADDR_I);
    if (bus.EN_W) bus.RDATA_W <= row_w(bus.ADDR_W);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic int clampi(input logic [3:0] f);
    return (f == 4'd0 || f > 4'd8) ? 8 : int'(f);
  endfunction

  // OUT(t,c) = sum over n<=N of IN(t,n)*W(c,n), zero outside T x M, mod 2^16.
  task automatic push_expected(input logic [11:0] mnt);
    int mm, nn, tt, t, c, val;
    logic [63:0] word;
    exp_t e;
    mm = clampi(mnt[11:8]);
    nn = clampi(mnt[7:4]);
    tt = clampi(mnt[3:0]);
    for (int k = 0; k < 16; k++) begin
      t = k / 2 + 1;
      word = '0;
      for (int j = 0; j < 4; j++) begin
        c = 4 * (k % 2) + j + 1;
        val = 0;
        if (t <= tt && c <= mm)
          for (int n = 1; n <= nn; n++)
            val += int'($signed(mem_i[t-1][n-1])) * int'($signed(mem_w[c-1][n-1]));
        word[63-16*j -: 16] = val[15:0];
      end
      e.addr = 4'(k);
      e.data = word;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge CLK) begin
    if (rst == 1'b0 && bus.EN_O === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %0d data %h, required no write", bus.ADDR_O, bus.WDATA_O);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rw_o", 64'(bus.RW_O), 64'd1);
        chk("addr_o", 64'(bus.ADDR_O), 64'(mon_e.addr));
        chk("wdata_o", bus.WDATA_O, mon_e.data);
      end
    end
  end

  task automatic check_quiet(input string name);
    chk({name, "_en_i"}, 64'(bus.EN_I), 64'd0);
    chk({name, "_en_w"}, 64'(bus.EN_W), 64'd0);
    chk({name, "_en_o"}, 64'(bus.EN_O), 64'd0);
  endtask

  task automatic do_run(input logic [11:0] mnt, input bit scramble);
    @(negedge CLK);
    bus.MNT   = mnt;
    bus.START = 1'b1;
    push_expected(mnt);
    @(posedge CLK);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == 0 && scramble) bus.MNT = 12'($urandom);
      chk("read_en_i", 64'(bus.EN_I), 64'd1);
      chk("read_en_w", 64'(bus.EN_W), 64'd1);
      chk("read_addr_i", 64'(bus.ADDR_I), 64'(i));
      chk("read_addr_w", 64'(bus.ADDR_W), 64'(i));
      chk("read_en_o", 64'(bus.EN_O), 64'd0);
    end
    @(negedge CLK);
    check_quiet("gap");
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      chk("write_en_o", 64'(bus.EN_O), 64'd1);
      chk("write_en_i", 64'(bus.EN_I), 64'd0);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      check_quiet("held_start");
    end
    bus.START = 1'b0;
    repeat (2) @(negedge CLK);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fill_random();
    for (int t = 0; t < 8; t++)
      for (int n = 0; n < 8; n++) begin
        mem_i[t][n] = 8'($urandom);
        mem_w[t][n] = 8'($urandom);
      end
  endtask

  task automatic fill_const(input logic [7:0] iv, input logic [7:0] wv);
    for (int t = 0; t < 8; t++)
      for (int n = 0; n < 8; n++) begin
        mem_i[t][n] = iv;
        mem_w[t][n] = wv;
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bus.START   = 1'b0;
    bus.MNT     = '0;
    bus.RDATA_O = '0;
    fill_const(8'h00, 8'h00);

    // Reset held for 10 cycles, then idle with START low.
    repeat (10) @(negedge CLK);
    chk("rst_en_w", 64'(bus.EN_W), 64'd0);
    chk("rst_en_i", 64'(bus.EN_I), 64'd0);
    chk("rst_en_o", 64'(bus.EN_O), 64'd0);
    chk("rst_rw_o", 64'(bus.RW_O), 64'd0);
    chk("rst_addr_w", 64'(bus.ADDR_W), 64'd0);
    chk("rst_addr_i", 64'(bus.ADDR_I), 64'd0);
    chk("rst_addr_o", 64'(bus.ADDR_O), 64'd0);
    chk("rst_wdata_o", bus.WDATA_O, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check_quiet("idle");
    end

    // Identity weights.
    for (int t = 0; t < 8; t++)
      for (int n = 0; n < 8; n++) begin
        mem_i[t][n] = 8'((t + 1) * 8 + (n + 1));
        mem_w[t][n] = (t == n) ? 8'd1 : 8'd0;
      end
    do_run(12'h763, 1'b0);

    fill_const(8'hFF, 8'h02);
    do_run(12'h888, 1'b0);
    fill_const(8'h80, 8'h80);
    do_run(12'h888, 1'b0);
    fill_const(8'h01, 8'h01);
    do_run(12'h838, 1'b0);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      do_run(12'($urandom), 1'b1);
    end

    // Abort during write k=5.
    fill_random();
    @(negedge CLK);
    bus.MNT   = 12'h888;
    bus.START = 1'b1;
    push_expected(12'h888);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      if (bus.EN_O === 1'b1 && bus.ADDR_O === 4'd4) found = 1'b1;
    end
    chk("midrun_reached_k4", 64'(found), 64'd1);
    @(posedge CLK);
    #2;
    chk("midrun_addr_o_k5", 64'(bus.ADDR_O), 64'd5);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrun_en_o", 64'(bus.EN_O), 64'd0);
    chk("midrun_rw_o", 64'(bus.RW_O), 64'd0);
    chk("midrun_addr_o", 64'(bus.ADDR_O), 64'd0);
    chk("midrun_wdata_o", bus.WDATA_O, 64'd0);
    chk("midrun_en_i", 64'(bus.EN_I), 64'd0);
    repeat (3) @(negedge CLK);
    bus.START = 1'b0;
    @(negedge CLK);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check_quiet("post_reset");
    end
    fill_random();
    do_run(12'h5A7, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
